// File: rtl/dut_regbank.sv
// Register bank slave with a programmable wait-state handshake, out-of-range error
// flagging and a saturating write counter. Optional byte strobes: REG_WSTRB_EN.
module dut_regbank #(
  parameter int DW          = 8,
  parameter int AW          = 8,
  parameter int DEPTH       = 16,
  parameter int WAIT_CYCLES = 0,
  parameter int CW          = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          wr,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
`ifdef REG_WSTRB_EN
  input  logic [DW/8-1:0] wstrb,
`endif
  output logic          ready,
  output logic [DW-1:0] rdata,
  output logic          rvalid,
  output logic          wack,
  output logic          err,
  output logic [CW-1:0] wr_count
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [7:0] WLOAD = (WAIT_CYCLES > 0) ? 8'(WAIT_CYCLES - 1) : 8'd0;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t        state, state_n;
  logic [DW-1:0] mem [DEPTH];
  logic          wr_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [7:0]    wcnt;
  logic          accept;
  logic          cur_wr;
  logic [AW-1:0] cur_addr;
  logic          cur_hit;
  logic          hit_q;
`ifdef REG_WSTRB_EN
  logic [DW/8-1:0] wstrb_q;
`endif

  function automatic logic in_range(input logic [AW-1:0] a);
    return {1'b0, a} < (AW+1)'(DEPTH);
  endfunction

  always_comb begin
    state_n = state;
    accept  = en && ready && (state == IDLE);
    case (state)
      IDLE:    if (accept) state_n = (WAIT_CYCLES > 0) ? WAIT : RESP;
      WAIT:    if (wcnt == 8'd0) state_n = RESP;
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    // With zero wait states RESP is entered straight from the accept edge, so the
    // response is formed from the live bus rather than the not-yet-latched copy.
    cur_wr   = accept ? wr   : wr_q;
    cur_addr = accept ? addr : addr_q;
    cur_hit  = in_range(cur_addr);
    hit_q    = in_range(addr_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ready    <= 1'b1;
      rdata    <= '0;
      rvalid   <= 1'b0;
      wack     <= 1'b0;
      err      <= 1'b0;
      wr_count <= '0;
      wcnt     <= '0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
`ifdef REG_WSTRB_EN
      wstrb_q  <= '0;
`endif
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      state <= state_n;
      ready <= (state_n == IDLE);

      if (accept) begin
        wr_q    <= wr;
        addr_q  <= addr;
        wdata_q <= wdata;
        wcnt    <= WLOAD;
`ifdef REG_WSTRB_EN
        wstrb_q <= wstrb;
`endif
      end else if (state == WAIT && wcnt != 8'd0) begin
        wcnt <= wcnt - 8'd1;
      end

      rvalid <= 1'b0;
      wack   <= 1'b0;
      err    <= 1'b0;
      rdata  <= '0;
      if (state_n == RESP) begin
        rvalid <= !cur_wr;
        wack   <= cur_wr;
        err    <= !cur_hit;
        if (!cur_wr && cur_hit) rdata <= mem[cur_addr[IW-1:0]];
      end

      if (state == RESP && wr_q && hit_q) begin
`ifdef REG_WSTRB_EN
        for (int unsigned i = 0; i < DW/8; i++)
          if (wstrb_q[i]) mem[addr_q[IW-1:0]][8*i +: 8] <= wdata_q[8*i +: 8];
`else
        mem[addr_q[IW-1:0]] <= wdata_q;
`endif
        if (wr_count != '1) wr_count <= wr_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dut_regbank.sv
// Scoreboard bench for dut_regbank: a CW=16 and a CW=2 instance share one bus;
// expected responses are queued at accept and checked when the pulse appears.
module tb_dut_regbank;
`ifdef REG_WSTRB_EN
  localparam int DW = 16;
`else
  localparam int DW = 8;
`endif
  localparam int AW    = 8;
  localparam int DEPTH = 16;
  localparam int WC    = 2;
  localparam int CW    = 16;

  typedef struct {
    logic          w;
    logic          e;
    logic [DW-1:0] d;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst, en, wr;
  logic [AW-1:0]   addr;
  logic [DW-1:0]   wdata;
  logic [DW/8-1:0] wstrb;
  logic            ready, rvalid, wack, err;
  logic [DW-1:0]   rdata;
  logic [CW-1:0]   wr_count;
  logic            ready2, rvalid2, wack2, err2;
  logic [DW-1:0]   rdata2;
  logic [1:0]      wr_count2;

  exp_t            q[$];
  exp_t            mon_e;
  logic [DW-1:0]   mdl [DEPTH];
  int unsigned     mcnt;
  int              n_cmp = 0;
  int              n_bad = 0;
  logic            mon_on = 1'b0;
  time             t_acc [4];

  dut_regbank #(.DW(DW), .AW(AW), .DEPTH(DEPTH), .WAIT_CYCLES(WC), .CW(CW)) dut (
    .clk(clk), .rst(rst), .en(en), .wr(wr), .addr(addr), .wdata(wdata),
`ifdef REG_WSTRB_EN
    .wstrb(wstrb),
`endif
    .ready(ready), .rdata(rdata), .rvalid(rvalid), .wack(wack), .err(err),
    .wr_count(wr_count)
  );

  dut_regbank #(.DW(DW), .AW(AW), .DEPTH(DEPTH), .WAIT_CYCLES(WC), .CW(2)) dut2 (
    .clk(clk), .rst(rst), .en(en), .wr(wr), .addr(addr), .wdata(wdata),
`ifdef REG_WSTRB_EN
    .wstrb(wstrb),
`endif
    .ready(ready2), .rdata(rdata2), .rvalid(rvalid2), .wack(wack2), .err(err2),
    .wr_count(wr_count2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] sat2();
    return (mcnt > 3) ? 64'd3 : 64'(mcnt);
  endfunction

  always @(negedge clk) begin
    if (mon_on) begin
      if (rvalid || wack) begin
        if (q.size() == 0) begin
          chk("unexpected_resp", 1, 0);
        end else begin
          mon_e = q.pop_front();
          chk("wack", wack, mon_e.w);
          chk("rvalid", rvalid, !mon_e.w);
          chk("err", err, mon_e.e);
          chk("rdata", rdata, mon_e.d);
          chk("dut2_resp", {wack2, rvalid2, err2, rdata2}, {mon_e.w, !mon_e.w, mon_e.e, mon_e.d});
        end
      end else begin
        chk("idle_outs", {err, rdata}, 0);
        chk("dut2_idle_outs", {rvalid2, wack2, err2, rdata2}, 0);
      end
    end
  end

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
    mcnt = 0;
  endtask

  // Present a request (caller at a negedge or just after a posedge), wait for accept,
  // then queue the expected response and update the model.
  task automatic issue(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic [DW/8-1:0] s, input logic hold, output time t);
    exp_t            e;
    int              n;
    logic [DW-1:0]   mask;
    logic            hit;
    en = 1'b1; wr = w; addr = a; wdata = d; wstrb = s;
    n = 0;
    while (!(ready && ready2) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!ready) chk("accept_timeout", 0, 1);
    @(posedge clk);
    t = $time;
    #1;
    if (!hold) en = 1'b0;
    hit = (a < DEPTH);
    e.w = w;
    e.e = !hit;
    e.d = (!w && hit) ? mdl[a[3:0]] : '0;
    if (w && hit) begin
`ifdef REG_WSTRB_EN
      for (int i = 0; i < DW/8; i++) mask[8*i +: 8] = {8{s[i]}};
`else
      mask = '1;
`endif
      mdl[a[3:0]] = (mdl[a[3:0]] & ~mask) | (d & mask);
      if (mcnt < 65535) mcnt++;
    end
    q.push_back(e);
  endtask

  task automatic txn(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                     input logic [DW/8-1:0] s);
    int  c;
    time t;
    issue(w, a, d, s, 1'b0, t);
    c = 0;
    do begin
      @(negedge clk);
      c++;
      chk("ready_busy", ready, 0);
    end while (!(rvalid || wack) && c < 50);
    chk("latency", c, WC + 1);
    @(negedge clk);
    chk("ready_back", ready, 1);
    chk("wr_count", wr_count, mcnt);
    chk("wr_count2", wr_count2, sat2());
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    model_reset();
  endtask

  initial begin
    time t;
    int  c;
    rst = 1'b1; en = 1'b0; wr = 1'b0; addr = '0; wdata = '0; wstrb = '0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_ready", ready, 1);
    chk("rst_outs", {rvalid, wack, err, rdata}, 0);
    chk("rst_wr_count", wr_count, 0);
    rst = 1'b0;
    mon_on = 1'b1;

    // basic write/read-back and out-of-range access
    txn(1'b1, 8'd5, DW'('h11), '1);
    txn(1'b0, 8'd5, '0, '1);
    txn(1'b1, 8'd22, DW'('h11), '1);
    txn(1'b0, 8'd22, '0, '1);
    txn(1'b1, 8'd15, DW'('h5A), '1);
    txn(1'b0, 8'd15, '0, '1);
    txn(1'b1, 8'd16, DW'('h77), '1);
    txn(1'b0, 8'd16, '0, '1);

    for (int i = 0; i < 10; i++)
      txn(1'($urandom_range(0, 1)), 8'($urandom_range(0, 19)), DW'($urandom), '1);

    // reset during WAIT discards the write
    txn(1'b1, 8'd3, DW'('h33), '1);
    issue(1'b1, 8'd3, DW'('hAA), '1, 1'b0, t);
    @(negedge clk);
    rst = 1'b1;
    q.delete();
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    chk("ready_after_rst", ready, 1);
    chk("wr_count_after_rst", wr_count, 0);
    repeat (4) @(negedge clk);
    txn(1'b0, 8'd3, '0, '1);

    // back-to-back writes with en held high
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      issue(1'b1, 8'(k + 8), DW'(k * 17 + 1), '1, 1'b1, t);
      t_acc[k] = t;
    end
    en = 1'b0;
    for (int k = 1; k < 4; k++) chk("b2b_spacing", 64'((t_acc[k] - t_acc[k-1]) / 10), 4);
    c = 0;
    while (q.size() != 0 && c < 50) begin
      @(negedge clk);
      c++;
    end
    chk("b2b_drain", q.size(), 0);
    @(negedge clk);
    chk("b2b_wr_count", wr_count, 4);
    chk("b2b_wr_count2", wr_count2, 3);
    for (int k = 0; k < 4; k++) txn(1'b0, 8'(k + 8), '0, '1);

    // saturation of the 2-bit counter: 1,2,3,3,3
    do_reset();
    for (int k = 0; k < 5; k++) txn(1'b1, 8'(k), DW'(k + 3), '1);

`ifdef REG_WSTRB_EN
    txn(1'b1, 8'd1, DW'('hBEEF), 2'b11);
    txn(1'b1, 8'd1, DW'('h1234), 2'b01);
    txn(1'b0, 8'd1, '0, '1);
    chk("wstrb_model", mdl[1], DW'('hBE34));
    txn(1'b1, 8'd1, DW'('hFFFF), 2'b00);
    txn(1'b0, 8'd1, '0, '1);
`endif

    repeat (5) @(negedge clk);
    chk("queue_empty", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
